// File: rtl/irrigation_scheduler_if.sv
// irrigation_scheduler_if: sensor inputs and actuator/status outputs of the irrigation scheduler
interface irrigation_scheduler_if #(parameter int N_ZONES = 4);
  localparam int ZW = N_ZONES > 1 ? $clog2(N_ZONES) : 1;
  logic tick;
  logic lvl_h;
  logic lvl_m;
  logic lvl_l;
  logic [N_ZONES-1:0] soil_dry;
  logic air_dry;
  logic temp_high;
  logic valve_in;
  logic [N_ZONES-1:0] sprinkler;
  logic [N_ZONES-1:0] drip;
  logic [ZW-1:0] zone_idx;
  logic busy;
  logic done;
  logic alarm;
  logic error;
  modport master (
    output tick, lvl_h, lvl_m, lvl_l, soil_dry, air_dry, temp_high,
    input valve_in, sprinkler, drip, zone_idx, busy, done, alarm, error
  );
  modport slave (
    input tick, lvl_h, lvl_m, lvl_l, soil_dry, air_dry, temp_high,
    output valve_in, sprinkler, drip, zone_idx, busy, done, alarm, error
  );
endinterface

// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: level debounce, inlet hysteresis and timed round-robin zone watering
module irrigation_scheduler #(
  parameter int N_ZONES = 4,
  parameter int DEB_TICKS = 3,
  parameter int SPR_TICKS = 10,
  parameter int DRIP_TICKS = 20,
  parameter int SETTLE_TICKS = 2
) (
  input logic clk,
  input logic rst,
  irrigation_scheduler_if.slave bus
);
  localparam int ZW = N_ZONES > 1 ? $clog2(N_ZONES) : 1;
  localparam int M1 = SPR_TICKS > DRIP_TICKS ? SPR_TICKS : DRIP_TICKS;
  localparam int M2 = SETTLE_TICKS > DEB_TICKS ? SETTLE_TICKS : DEB_TICKS;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  typedef enum logic [1:0] {IDLE, WATER, SETTLE} state_t;
  state_t state, state_n;
  logic [2:0] raw, filt;
  logic [2:0][CW-1:0] dcnt;
  logic [CW-1:0] cnt;
  logic [ZW-1:0] ptr, zone, sel, zone_n;
  logic mode, mode_n, hit, ld, fin, err_c;
  logic [N_ZONES-1:0] spr_n, drip_n;
  assign raw = {bus.lvl_h, bus.lvl_m, bus.lvl_l};
  assign err_c = (filt[1] & ~filt[0]) | (filt[2] & ~filt[1]);
  assign ld = state == IDLE && state_n == WATER;
  assign fin = state == WATER && state_n == SETTLE;
  assign bus.zone_idx = zone;
  // a filtered level bit follows its raw sensor only after DEB_TICKS consecutive differing ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '0;
      dcnt <= '0;
    end else if (bus.tick) begin
      for (int i = 0; i < 3; i++) begin
        if (raw[i] == filt[i]) dcnt[i] <= '0;
        else if (dcnt[i] == CW'(DEB_TICKS - 1)) begin
          filt[i] <= raw[i];
          dcnt[i] <= '0;
        end else dcnt[i] <= dcnt[i] + CW'(1);
      end
    end
  end
  // tank status: inconsistency error, alarm, and inlet valve with hysteresis (clear wins)
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.error <= 1'b0;
      bus.alarm <= 1'b0;
      bus.valve_in <= 1'b0;
    end else begin
      bus.error <= err_c;
      bus.alarm <= err_c | ~filt[0];
      bus.valve_in <= (filt[2] | err_c) ? 1'b0 : ~filt[1] | bus.valve_in;
    end
  end
  // first dry zone after the round-robin pointer, the pointer itself checked last
  always_comb begin
    hit = 1'b0;
    sel = ptr;
    for (int k = N_ZONES; k >= 1; k--)
      if (bus.soil_dry[ZW'((int'(ptr) + k) % N_ZONES)]) begin
        hit = 1'b1;
        sel = ZW'((int'(ptr) + k) % N_ZONES);
      end
  end
  // scheduler state, latched zone/mode, shared tick counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= ZW'(N_ZONES - 1);
      zone <= '0;
      mode <= 1'b0;
    end else begin
      state <= state_n;
      zone <= zone_n;
      mode <= mode_n;
      if (ld) cnt <= mode_n ? CW'(DRIP_TICKS) : CW'(SPR_TICKS);
      else if (fin) begin
        cnt <= CW'(SETTLE_TICKS);
        ptr <= zone;
      end else if (bus.tick && cnt != '0) cnt <= cnt - CW'(1);
    end
  end
  // next state: alarm aborts any activity; watering ends on expiry or when the zone is no longer dry
  always_comb begin
    state_n = state;
    if (state != IDLE && bus.alarm) state_n = IDLE;
    else if (state == IDLE) state_n = bus.tick && !bus.alarm && hit ? WATER : IDLE;
    else if (state == WATER) state_n = bus.tick && (cnt == CW'(1) || !bus.soil_dry[zone]) ? SETTLE : WATER;
    else state_n = cnt == '0 || (bus.tick && cnt == CW'(1)) ? IDLE : SETTLE;
  end
  // outputs follow the next state so the actuators are off in every non-WATER state
  always_comb begin
    zone_n = ld ? sel : zone;
    mode_n = ld ? bus.air_dry & bus.temp_high : mode;
    spr_n = state_n == WATER && !mode_n ? N_ZONES'(1) << zone_n : '0;
    drip_n = state_n == WATER && mode_n ? N_ZONES'(1) << zone_n : '0;
  end
  // registered actuator and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sprinkler <= '0;
      bus.drip <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.sprinkler <= spr_n;
      bus.drip <= drip_n;
      bus.busy <= state_n != IDLE;
      bus.done <= fin;
    end
  end
endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb_irrigation_scheduler: directed and random checks of irrigation_scheduler against a tick-level model
module tb_irrigation_scheduler;
  localparam int N = 4, DEB = 2, SPR = 3, DRIP = 5, SET = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cc = 0, n_chk = 0, n_fail = 0;
  bit [2:0] mf = '0;
  int streak [3] = '{0, 0, 0};
  bit m_err = 0, m_alarm = 0, m_valve = 0, m_done = 0, m_drip = 0;
  int phase = 0, left = 0, zone = 0, ptr = N - 1;
  irrigation_scheduler_if #(.N_ZONES(N)) bus();
  irrigation_scheduler #(
    .N_ZONES(N), .DEB_TICKS(DEB), .SPR_TICKS(SPR), .DRIP_TICKS(DRIP), .SETTLE_TICKS(SET)
  ) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_step();
    bit e, old_alarm;
    bit [2:0] raw;
    bit [N-1:0] sd;
    raw = {bus.lvl_h, bus.lvl_m, bus.lvl_l};
    sd = bus.soil_dry;
    if (rst) begin
      mf = '0;
      streak = '{0, 0, 0};
      m_err = 0; m_alarm = 0; m_valve = 0; m_done = 0; m_drip = 0;
      phase = 0; left = 0; zone = 0; ptr = N - 1;
      return;
    end
    e = (mf[1] && !mf[0]) || (mf[2] && !mf[1]);
    old_alarm = m_alarm;
    m_err = e;
    m_alarm = e || !mf[0];
    if (mf[2] || e) m_valve = 0;
    else if (!mf[1]) m_valve = 1;
    if (bus.tick)
      for (int i = 0; i < 3; i++)
        if (raw[i] != mf[i]) begin
          streak[i]++;
          if (streak[i] == DEB) begin
            mf[i] = raw[i];
            streak[i] = 0;
          end
        end else streak[i] = 0;
    m_done = 0;
    if (phase != 0 && old_alarm) phase = 0;
    else if (phase == 0) begin
      if (bus.tick && !old_alarm)
        for (int k = 1; k <= N; k++)
          if (phase == 0 && sd[(ptr + k) % N]) begin
            zone = (ptr + k) % N;
            m_drip = bus.air_dry && bus.temp_high;
            left = m_drip ? DRIP : SPR;
            phase = 1;
          end
    end else if (phase == 1) begin
      if (bus.tick) begin
        left--;
        if (left == 0 || !sd[zone]) begin
          m_done = 1;
          ptr = zone;
          phase = 2;
          left = SET;
        end
      end
    end else if (left == 0) phase = 0;
    else if (bus.tick) begin
      left--;
      if (left == 0) phase = 0;
    end
  endtask
  task automatic check_all();
    logic [N-1:0] oh;
    oh = N'(1) << zone;
    chk("valve_in", bus.valve_in, m_valve);
    chk("alarm", bus.alarm, m_alarm);
    chk("error", bus.error, m_err);
    chk("done", bus.done, m_done);
    chk("busy", bus.busy, phase != 0);
    chk("sprinkler", bus.sprinkler, phase == 1 && !m_drip ? oh : '0);
    chk("drip", bus.drip, phase == 1 && m_drip ? oh : '0);
    chk("zone_idx", bus.zone_idx, zone);
  endtask
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
      cc++;
      bus.tick = cc % 4 == 0;
    end
  endtask
  task automatic ticks(input int n);
    cyc(4 * n);
  endtask
  task automatic wait_on(input string tag, input int lim, input bit want_done);
    bit seen;
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      cyc(1);
      seen = want_done ? bus.done : (bus.sprinkler | bus.drip) != '0;
    end
    chk(tag, seen, 1);
  endtask
  task automatic set_lvl(input bit h, input bit m, input bit l);
    bus.lvl_h = h;
    bus.lvl_m = m;
    bus.lvl_l = l;
  endtask
  initial begin
    bit [2:0] lv;
    bus.tick = 0;
    set_lvl(0, 0, 0);
    bus.soil_dry = '0;
    bus.air_dry = 0;
    bus.temp_high = 0;
    cyc(3);
    chk("rst_alarm", bus.alarm, 0);
    chk("rst_valve", bus.valve_in, 0);
    chk("rst_sprinkler", bus.sprinkler, 0);
    chk("rst_zone", bus.zone_idx, 0);
    rst = 0;
    cyc(1);
    chk("empty_alarm", bus.alarm, 1);
    bus.lvl_l = 1;
    ticks(1);
    bus.lvl_l = 0;
    ticks(3);
    chk("glitch_alarm", bus.alarm, 1);
    bus.lvl_l = 1;
    ticks(3);
    chk("debounced_alarm", bus.alarm, 0);
    chk("valve_l", bus.valve_in, 1);
    bus.lvl_m = 1;
    ticks(3);
    chk("valve_lm", bus.valve_in, 1);
    bus.lvl_h = 1;
    ticks(3);
    chk("valve_lmh", bus.valve_in, 0);
    bus.lvl_h = 0;
    ticks(3);
    chk("valve_drop_h", bus.valve_in, 0);
    bus.lvl_m = 0;
    ticks(3);
    chk("valve_drop_m", bus.valve_in, 1);
    bus.lvl_m = 1;
    ticks(3);
    bus.soil_dry = 4'b1010;
    wait_on("rr_start", 40, 0);
    chk("rr_first", bus.sprinkler, 4'b0010);
    wait_on("rr_done", 40, 1);
    wait_on("rr_next", 40, 0);
    chk("rr_second", bus.sprinkler, 4'b1000);
    bus.soil_dry = '0;
    ticks(6);
    bus.air_dry = 1;
    bus.temp_high = 1;
    bus.soil_dry = 4'b0001;
    wait_on("drip_start", 40, 0);
    chk("drip_mode", bus.drip, 4'b0001);
    chk("drip_no_spr", bus.sprinkler, 0);
    ticks(2);
    bus.soil_dry = '0;
    wait_on("early_done", 8, 1);
    chk("early_drip_off", bus.drip, 0);
    bus.air_dry = 0;
    bus.temp_high = 0;
    ticks(3);
    bus.soil_dry = 4'b0100;
    wait_on("err_start", 40, 0);
    chk("err_spr_on", bus.sprinkler, 4'b0100);
    set_lvl(1, 0, 1);
    ticks(4);
    chk("err_error", bus.error, 1);
    chk("err_alarm", bus.alarm, 1);
    chk("err_valve", bus.valve_in, 0);
    chk("err_spr_off", bus.sprinkler, 0);
    chk("err_busy", bus.busy, 0);
    set_lvl(0, 1, 1);
    ticks(4);
    wait_on("rst_start", 40, 0);
    chk("rst_spr_on", bus.sprinkler, 4'b0100);
    rst = 1;
    cyc(1);
    chk("midrst_spr", bus.sprinkler, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_zone", bus.zone_idx, 0);
    rst = 0;
    bus.soil_dry = 4'b1111;
    wait_on("post_rst_start", 60, 0);
    chk("post_rst_zone0", bus.sprinkler, 4'b0001);
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0: lv = 3'($urandom);
        1, 2: lv = 3'((1 << $urandom_range(0, 3)) - 1);
        default: lv = {bus.lvl_h, bus.lvl_m, bus.lvl_l};
      endcase
      set_lvl(lv[2], lv[1], lv[0]);
      if ($urandom_range(0, 2) == 0) bus.soil_dry = N'($urandom);
      bus.air_dry = 1'($urandom);
      bus.temp_high = 1'($urandom);
      rst = $urandom_range(0, 60) == 0;
      cyc($urandom_range(1, 12));
      rst = 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
